// File: rtl/dma_controller_pkg.sv
// Shared constants and state encoding for the device-to-memory DMA controller.
package dma_controller_pkg;

  localparam int DMA_WORD_SIZE      = 16;
  localparam int DMA_DEVICE_BIT_LEN = 2;
  localparam int DMA_BLOCKS         = 3;
  localparam int DATA_SIZE          = DMA_BLOCKS;
  localparam int DMA_ADDR_WIDTH     = 16;
  localparam int BLOCK_STRIDE       = 4;
  localparam int BLOCK_SHIFT        = $clog2(BLOCK_STRIDE);

  // All-ones offset parks the device; it drives nothing for this code.
  localparam logic [DMA_DEVICE_BIT_LEN-1:0] OFFSET_IDLE = '1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_FETCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } dma_state_t;

endpackage

// File: rtl/dma_controller.sv
// Copies 4-word blocks from the external device into memory after a CPU command,
// holding the bus via BR/BG and raising a one-cycle dma_end when finished.
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter int WORD_SIZE      = DMA_WORD_SIZE,
  parameter int DEVICE_BIT_LEN = DMA_DEVICE_BIT_LEN,
  parameter int BLOCKS         = DMA_BLOCKS,
  parameter int ADDR_WIDTH     = DMA_ADDR_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cmd_valid,
  input  logic [ADDR_WIDTH-1:0]              cmd_addr,
  input  logic [DEVICE_BIT_LEN-1:0]          cmd_length,
  input  logic                               BG,
  output logic                               BR,
  output logic [DEVICE_BIT_LEN-1:0]          offset,
  input  logic [BLOCK_STRIDE*WORD_SIZE-1:0]  dev_data,
  output logic                               mem_write,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [BLOCK_STRIDE*WORD_SIZE-1:0]  mem_data,
  input  logic                               mem_ready,
  output logic                               dma_end
);

  localparam int LW = DEVICE_BIT_LEN;
  localparam logic [LW:0]   BLOCKS_W   = BLOCKS[LW:0];
  localparam logic [LW-1:0] W_OFF_IDLE = '1;

  dma_state_t            r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base, w_base_nxt;
  logic [LW-1:0]         r_len, w_len_nxt;
  logic [LW-1:0]         r_index, w_index_nxt;
  logic                  r_zero_pend, w_zero_pend_nxt;
  logic                  w_capture;
  logic [LW-1:0]         w_len_clamp;
  logic [LW:0]           w_index_inc;
  logic [ADDR_WIDTH-1:0] w_blk_addr;

  assign w_len_clamp = ({1'b0, cmd_length} > BLOCKS_W) ? BLOCKS_W[LW-1:0] : cmd_length;
  assign w_index_inc = {1'b0, r_index} + {{LW{1'b0}}, 1'b1};
  assign w_blk_addr  = r_base + ({{(ADDR_WIDTH-LW){1'b0}}, r_index} << BLOCK_SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_index     <= '0;
      r_zero_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_len       <= w_len_nxt;
      r_index     <= w_index_nxt;
      r_zero_pend <= w_zero_pend_nxt;
    end
  end

  // A zero-length command spends one IDLE cycle in r_zero_pend so that dma_end
  // lands two cycles after cmd_valid, matching the 2+2*len latency rule.
  always_comb begin
    w_state_nxt     = r_state;
    w_base_nxt      = r_base;
    w_len_nxt       = r_len;
    w_index_nxt     = r_index;
    w_zero_pend_nxt = r_zero_pend;
    w_capture       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_zero_pend) begin
          w_zero_pend_nxt = 1'b0;
          w_state_nxt     = ST_DONE;
        end else if (cmd_valid) begin
          w_base_nxt = cmd_addr;
          w_len_nxt  = w_len_clamp;
          if (w_len_clamp == '0) w_zero_pend_nxt = 1'b1;
          else                   w_state_nxt     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (BG) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (!BG) begin
          w_state_nxt = ST_REQ;
        end else begin
          w_state_nxt = ST_WRITE;
          w_capture   = 1'b1;
        end
      end
      ST_WRITE: begin
        // A write accepted in the same cycle the bus is reclaimed still counts.
        if (mem_ready) begin
          w_index_nxt = w_index_inc[LW-1:0];
          w_state_nxt = (w_index_inc == {1'b0, r_len}) ? ST_DONE : ST_FETCH;
        end else if (!BG) begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_DONE: begin
        w_index_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up
  // with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      BR        <= 1'b0;
      mem_write <= 1'b0;
      dma_end   <= 1'b0;
      offset    <= W_OFF_IDLE;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      BR        <= (w_state_nxt == ST_REQ) || (w_state_nxt == ST_FETCH) ||
                   (w_state_nxt == ST_WRITE);
      mem_write <= (w_state_nxt == ST_WRITE);
      dma_end   <= (w_state_nxt == ST_DONE);
      offset    <= ((w_state_nxt == ST_FETCH) || (w_state_nxt == ST_WRITE)) ?
                   w_index_nxt : W_OFF_IDLE;
      if (w_capture) begin
        mem_addr <= w_blk_addr;
        mem_data <= dev_data;
      end
    end
  end

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: vector table of transfers plus hand-written
// reset, stall, reclaim, ignored-command and clamp sequences.
module tb_dma_controller;
  import dma_controller_pkg::*;

  localparam int AW = 16;
  localparam int DW = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- main DUT (BLOCKS=3) ----------------
  logic          cmd_valid, BG, BR, mem_write, mem_ready, dma_end;
  logic [AW-1:0] cmd_addr, mem_addr;
  logic [1:0]    cmd_length, offset;
  logic [DW-1:0] dev_data, mem_data;

  // ---------------- clamp DUT (BLOCKS=2) ----------------
  logic          cmd_valid_b, BG_b, BR_b, mem_write_b, mem_ready_b, dma_end_b;
  logic [AW-1:0] cmd_addr_b, mem_addr_b;
  logic [1:0]    cmd_length_b, offset_b;
  logic [DW-1:0] dev_data_b, mem_data_b;

  logic [DW-1:0] store [0:3];
  assign dev_data   = store[offset];
  assign dev_data_b = store[offset_b];
  assign BG_b       = BR_b;

  dma_controller dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
    .cmd_length(cmd_length), .BG(BG), .BR(BR), .offset(offset),
    .dev_data(dev_data), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(mem_ready), .dma_end(dma_end)
  );

  dma_controller #(.BLOCKS(2)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_b), .cmd_addr(cmd_addr_b),
    .cmd_length(cmd_length_b), .BG(BG_b), .BR(BR_b), .offset(offset_b),
    .dev_data(dev_data_b), .mem_write(mem_write_b), .mem_addr(mem_addr_b),
    .mem_data(mem_data_b), .mem_ready(mem_ready_b), .dma_end(dma_end_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int wr_cnt_b = 0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [AW+DW-1:0] act,
                     input logic [AW+DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && mem_write && mem_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL extra_write: got write addr %0h data %0h, expected none",
                 mem_addr, mem_data);
      end else begin
        chk("write", {mem_addr, mem_data}, exp_q.pop_front());
      end
    end
    if (!reset && mem_write_b && mem_ready_b) wr_cnt_b++;
  end

  // ---------------- driver ----------------
  task automatic run_xfer(input logic [AW-1:0] addr, input logic [1:0] len,
                          input int stall_blk, input int stall_n,
                          input int reclaim_blk, input bit poke,
                          output int end_cyc, output bit br_seen);
    int cyc, stall_cnt, bg_low;
    bit stall_done, reclaim_done, poked;
    for (int i = 0; i < int'(len); i++)
      exp_q.push_back({addr + 16'(4 * i), store[i]});
    end_cyc = -1; br_seen = 0; cyc = 0; stall_cnt = 0; bg_low = 0;
    stall_done = 0; reclaim_done = 0; poked = 0;
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_addr = addr; cmd_length = len; BG = 1'b0; mem_ready = 1'b1;
    while (cyc < 100 && end_cyc < 0) begin
      @(posedge clk); #2;
      cyc++;
      cmd_valid = 1'b0;
      if (BR) br_seen = 1;
      if (poke && !poked && BR && offset == 2'b11 && !mem_write) begin
        cmd_valid = 1'b1; cmd_addr = 16'h5555; cmd_length = 2'd3; poked = 1;
      end
      if (bg_low > 0) begin
        BG = 1'b0; bg_low--;
      end else if (!reclaim_done && BR && !mem_write && int'(offset) == reclaim_blk) begin
        BG = 1'b0; bg_low = 3; reclaim_done = 1;
      end else begin
        BG = BR;
      end
      if (!stall_done && (stall_cnt > 0 || (mem_write && int'(offset) == stall_blk))) begin
        chk("stall_mem_write", mem_write, 1);
        chk("stall_addr", mem_addr, addr + 16'(4 * stall_blk));
        chk("stall_data", mem_data, store[stall_blk]);
        if (stall_cnt < stall_n) begin
          mem_ready = 1'b0; stall_cnt++;
        end else begin
          mem_ready = 1'b1; stall_done = 1;
        end
      end else begin
        mem_ready = 1'b1;
      end
      if (dma_end) begin
        end_cyc = cyc;
        chk("br_low_at_end", BR, 0);
        chk("mem_write_low_at_end", mem_write, 0);
      end
    end
    if (end_cyc < 0) begin
      checks++; failures++;
      $display("FAIL timeout: got no dma_end within 100 cycles, expected one");
    end
    if (stall_blk >= 0) chk("stall_completed", stall_done, 1);
    chk("exp_q_drained", exp_q.size(), 0);
    exp_q.delete();
    BG = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    len;
    int            exp_end;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int end_cyc, cyc;
    bit br_seen;

    vecs[0] = '{16'h0100, 2'd3, 8};
    vecs[1] = '{16'h0200, 2'd1, 4};
    vecs[2] = '{16'hFFFC, 2'd2, 6};
    vecs[3] = '{16'h0040, 2'd0, 2};
    vecs[4] = '{16'h1230, 2'd2, 6};

    store[0] = 64'hAAAA_0001_AAAA_0002;
    store[1] = 64'hBBBB_0003_BBBB_0004;
    store[2] = 64'hCCCC_0005_CCCC_0006;
    store[3] = '0;

    cmd_valid = 0; cmd_addr = '0; cmd_length = '0; BG = 0; mem_ready = 0;
    cmd_valid_b = 0; cmd_addr_b = '0; cmd_length_b = '0; mem_ready_b = 1;
    reset = 0;
    #1 reset = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_BR", BR, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_dma_end", dma_end, 0);
    chk("rst_offset", offset, 2'b11);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    @(negedge clk) reset = 0;

    // Table of transfers with immediate grant and immediate mem_ready.
    for (int v = 0; v < 5; v++) begin
      run_xfer(vecs[v].addr, vecs[v].len, -1, 0, -1, 0, end_cyc, br_seen);
      chk($sformatf("vec%0d_end_cycle", v), end_cyc, vecs[v].exp_end);
      chk($sformatf("vec%0d_br_seen", v), br_seen, (vecs[v].len != 0));
    end

    // Memory stall: block 1 held for 5 extra cycles.
    run_xfer(16'h0100, 2'd3, 1, 5, -1, 0, end_cyc, br_seen);
    chk("stall_end_cycle", end_cyc, 13);

    // Bus reclaim during block 1 fetch, re-granted 4 cycles later.
    run_xfer(16'h0100, 2'd3, -1, 0, 1, 0, end_cyc, br_seen);
    chk("reclaim_end_cycle", end_cyc, 13);

    // Address wrap with a stray command pulsed during REQ.
    run_xfer(16'hFFFC, 2'd2, -1, 0, -1, 1, end_cyc, br_seen);
    chk("poke_end_cycle", end_cyc, 6);

    // Asynchronous reset mid-WRITE.
    @(posedge clk); #2;
    cmd_valid = 1; cmd_addr = 16'h0100; cmd_length = 2'd3; BG = 0; mem_ready = 0;
    @(posedge clk); #2;
    cmd_valid = 0; BG = 1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("pre_rst_mem_write", mem_write, 1);
    chk("pre_rst_BR", BR, 1);
    #1 reset = 1;
    #1;
    chk("async_rst_BR", BR, 0);
    chk("async_rst_mem_write", mem_write, 0);
    chk("async_rst_dma_end", dma_end, 0);
    chk("async_rst_offset", offset, 2'b11);
    chk("async_rst_mem_addr", mem_addr, 0);
    chk("async_rst_mem_data", mem_data, 0);
    @(negedge clk);
    reset = 0; BG = 0; mem_ready = 1;

    run_xfer(16'h0300, 2'd3, -1, 0, -1, 0, end_cyc, br_seen);
    chk("post_rst_end_cycle", end_cyc, 8);

    // Length clamp on the BLOCKS=2 instance.
    @(posedge clk); #2;
    wr_cnt_b = 0;
    cmd_valid_b = 1; cmd_addr_b = 16'h0800; cmd_length_b = 2'd3;
    cyc = 0; end_cyc = -1;
    while (cyc < 100 && end_cyc < 0) begin
      @(posedge clk); #2;
      cyc++;
      cmd_valid_b = 0;
      if (dma_end_b) end_cyc = cyc;
    end
    chk("clamp_end_cycle", end_cyc, 6);
    chk("clamp_write_count", wr_cnt_b, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
